// File: rtl/apb_interconnect_if.sv
// APB4 interconnect bundle: upstream master signals (m_*) and the fanned-out slave side (s_*).
// The ic modport is the interconnect's own view of both sides.
interface apb_interconnect_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SLAVE_NUM  = 8
);
   logic                            m_psel;
   logic                            m_penable;
   logic                            m_pwrite;
   logic [ADDR_WIDTH-1:0]           m_paddr;
   logic [DATA_WIDTH-1:0]           m_pwdata;
   logic [DATA_WIDTH/8-1:0]         m_pstrb;
   logic [2:0]                      m_pprot;
   logic [DATA_WIDTH-1:0]           m_prdata;
   logic                            m_pready;
   logic                            m_pslverr;

   logic [SLAVE_NUM-1:0]            s_psel;
   logic                            s_penable;
   logic                            s_pwrite;
   logic [ADDR_WIDTH-1:0]           s_paddr;
   logic [DATA_WIDTH-1:0]           s_pwdata;
   logic [DATA_WIDTH/8-1:0]         s_pstrb;
   logic [2:0]                      s_pprot;
   logic [SLAVE_NUM*DATA_WIDTH-1:0] s_prdata;
   logic [SLAVE_NUM-1:0]            s_pready;
   logic [SLAVE_NUM-1:0]            s_pslverr;

   modport master (
      output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot,
      input  m_prdata, m_pready, m_pslverr
   );

   modport slave (
      input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, s_pprot,
      output s_prdata, s_pready, s_pslverr
   );

   modport ic (
      input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot,
      output m_prdata, m_pready, m_pslverr,
      output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, s_pprot,
      input  s_prdata, s_pready, s_pslverr
   );
endinterface

// File: rtl/apb_interconnect.sv
// APB4 one-master/N-slave interconnect: address decode, response mux, local completion of
// unmapped and timed-out transfers, and sticky error status.
module apb_interconnect #(
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           SLAVE_NUM      = 8,
   parameter int unsigned           REGION_BITS    = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(32'h4000_0000),
   parameter int unsigned           TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   apb_interconnect_if.ic        bus,
   input  logic                  err_clr,
   output logic [15:0]           err_count,
   output logic [ADDR_WIDTH-1:0] last_err_addr,
   output logic [1:0]            last_err_type
);
   localparam int unsigned IDX_W   = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
   localparam int unsigned CMP_LSB = REGION_BITS + IDX_W;
   localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   state_e                st_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  mapped_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic [15:0]           cnt_q;

   logic [IDX_W-1:0]      idx;
   logic                  mapped;
   logic                  setup;
   logic                  abort;
   logic                  sel_ready;
   logic                  sel_err;
   logic [DATA_WIDTH-1:0] sel_rdata;
   logic                  resp_ready;
   logic                  done;
   logic                  err_ev;
   logic [1:0]            err_type;

   assign idx    = bus.m_paddr[REGION_BITS +: IDX_W];
   assign mapped = (bus.m_paddr[ADDR_WIDTH-1:CMP_LSB] == BASE_ADDR[ADDR_WIDTH-1:CMP_LSB]) &&
                   (32'(idx) < SLAVE_NUM);
   // Gated by reset so a master still holding psel cannot select a slave while in reset.
   assign setup  = (st_q == StIdle) && bus.m_psel && preset_n;
   assign abort  = (TIMEOUT_CYCLES != 0) && mapped_q && (cnt_q == TIMEOUT);

   assign bus.s_pwrite = bus.m_pwrite;
   assign bus.s_paddr  = bus.m_paddr;
   assign bus.s_pwdata = bus.m_pwdata;
   assign bus.s_pstrb  = bus.m_pstrb;
   assign bus.s_pprot  = bus.m_pprot;

   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
         if (32'(idx_q) == i) begin
            sel_ready = bus.s_pready[i];
            sel_err   = bus.s_pslverr[i];
            sel_rdata = bus.s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      bus.s_psel    = '0;
      bus.s_penable = 1'b0;
      bus.m_prdata  = '0;
      bus.m_pslverr = 1'b0;
      resp_ready    = 1'b0;
      if (st_q == StIdle) begin
         for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
            bus.s_psel[i] = setup && mapped && (32'(idx) == i);
         end
      end else if (!mapped_q || abort) begin
         resp_ready    = 1'b1;
         bus.m_pslverr = 1'b1;
      end else begin
         for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
            bus.s_psel[i] = (32'(idx_q) == i);
         end
         bus.s_penable = bus.m_penable;
         resp_ready    = sel_ready;
         bus.m_pslverr = sel_err;
         bus.m_prdata  = sel_rdata;
      end
   end

   assign bus.m_pready = resp_ready;
   assign done         = (st_q == StAccess) && bus.m_psel && resp_ready;

   always_comb begin
      err_type = 2'b00;
      if (!mapped_q) begin
         err_type = 2'b01;
      end else if (abort) begin
         err_type = 2'b10;
      end else if (sel_err) begin
         err_type = 2'b11;
      end
   end

   assign err_ev = done && (err_type != 2'b00);

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         st_q          <= StIdle;
         idx_q         <= '0;
         mapped_q      <= 1'b0;
         paddr_q       <= '0;
         cnt_q         <= '0;
         err_count     <= '0;
         last_err_addr <= '0;
         last_err_type <= 2'b00;
      end else begin
         unique case (st_q)
            StIdle: begin
               if (bus.m_psel) begin
                  st_q     <= StAccess;
                  idx_q    <= idx;
                  mapped_q <= mapped;
                  paddr_q  <= bus.m_paddr;
                  cnt_q    <= '0;
               end
            end
            StAccess: begin
               // A dropped psel abandons the transfer without logging anything.
               if (!bus.m_psel || done) begin
                  st_q  <= StIdle;
                  cnt_q <= '0;
               end else if (cnt_q != 16'hFFFF) begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: st_q <= StIdle;
         endcase

         if (err_ev) begin
            if (err_clr) begin
               err_count <= 16'd1;
            end else if (err_count != 16'hFFFF) begin
               err_count <= err_count + 16'd1;
            end
            last_err_addr <= paddr_q;
            last_err_type <= err_type;
         end else if (err_clr) begin
            err_count     <= '0;
            last_err_addr <= '0;
            last_err_type <= 2'b00;
         end
      end
   end
endmodule

// File: doc/apb_interconnect.md
# apb_interconnect

Parametrised APB4 interconnect connecting one APB master to SLAVE_NUM slaves. Decodes the setup-phase address into a one-hot slave select and muxes the selected slave's response back to the master. Completes unmapped and timed-out transfers itself with PSLVERR and records every error in sticky status registers. Sits between the APB bridge and the peripheral slaves.

## Interface
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8).
- SLAVE_NUM, 8, number of slave ports (1..16); IDX_W = max(1, $clog2(SLAVE_NUM)).
- REGION_BITS, 12, log2 bytes per slave window.
- BASE_ADDR, 32'h4000_0000, base of the slave map; only bits [ADDR_WIDTH-1:REGION_BITS+IDX_W] are compared.
- TIMEOUT_CYCLES, 16, access cycles allowed before abort (1..65535; 0 disables timeout).
- pclk  in  1  clock. The block has one clock.
- preset_n  in  1  reset, asynchronous and active-low.
- m_psel, m_penable, m_pwrite  in  1  master control.
- m_paddr  in  ADDR_WIDTH; m_pwdata  in  DATA_WIDTH; m_pstrb  in  DATA_WIDTH/8; m_pprot  in  3.
- m_prdata  out  DATA_WIDTH; m_pready, m_pslverr  out  1  master response.
- s_psel  out  SLAVE_NUM  one-hot slave select.
- s_penable, s_pwrite  out  1; s_paddr, s_pwdata, s_pstrb, s_pprot  out  (master widths)  broadcast to all slaves.
- s_prdata  in  SLAVE_NUM*DATA_WIDTH  slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_pready, s_pslverr  in  SLAVE_NUM.
- err_clr  in  1  synchronous clear of the status registers.
- err_count  out  16  saturating error count.
- last_err_addr  out  ADDR_WIDTH  address of the most recent error.
- last_err_type  out  2  00 none, 01 unmapped, 10 timeout, 11 slave PSLVERR.

## Operation
- States: IDLE, ACCESS.
- IDLE:
  - m_psel=1 marks the setup cycle.
  - idx = m_paddr[REGION_BITS +: IDX_W].
  - mapped = (upper bits equal BASE_ADDR) && (idx < SLAVE_NUM).
  - Setup cycle: s_psel[idx] = mapped (decoded combinationally); s_penable=0.
  - idx, mapped and paddr are latched; next state is ACCESS.
- ACCESS, mapped:
  - s_psel[idx]=1 and s_penable=m_penable.
  - m_pready, m_prdata and m_pslverr pass combinationally from slave idx.
  - Slave m_pready=1 completes the transfer; next state is IDLE.
- ACCESS, unmapped:
  - All s_psel are 0.
  - m_pready=1, m_pslverr=1 and m_prdata=0 in the first access cycle.
  - Error type 01 is logged.
- Timeout (TIMEOUT_CYCLES=T>0):
  - A 16-bit counter counts access cycles with s_pready[idx]=0.
  - If access cycles 1..T all see no pready, cycle T+1 is an abort cycle:
    - s_psel=0 and s_penable=0.
    - m_pready=1, m_pslverr=1, m_prdata=0.
    - Type 10 is logged.
  - A late pready from the slave is ignored.
- Slave completion with s_pslverr=1 is forwarded to the master and logged as type 11.
- s_paddr, s_pwdata, s_pwrite, s_pstrb and s_pprot are combinational copies of the master inputs.
- m_psel falling while in ACCESS is a protocol violation: the state returns to IDLE and nothing is logged.
- Logging:
  - Each error increments err_count, saturating at 16'hFFFF.
  - Each error loads last_err_addr with the latched paddr and loads last_err_type.
  - err_clr zeroes all three registers.
  - err_clr in the same cycle as an error: the error wins (err_count=1, fields loaded).

## Timing
- Reset values:
  - State IDLE, counter 0.
  - s_psel=0, s_penable=0.
  - m_pready=0, m_pslverr=0, m_prdata=0.
  - err_count=0, last_err_addr=0, last_err_type=00.
- Reset asserted mid-transfer forces these values immediately (asynchronous).
- Mapped path adds zero wait states; the response path is combinational.
- Unmapped transfers complete with zero wait states.
- Timeout transfers complete in exactly T+1 access cycles.
- m_pready is 0 whenever the state is IDLE.
- Back-to-back transfers: a new setup is accepted in the cycle after the completing access cycle.
- Status registers update on the clock edge ending the completing access cycle.

## Test plan
- Write 0x4000_2010, data 0xDEAD_BEEF, slave 2 pready held high -> s_psel=8'h04 in setup and access, 0 wait states, err_count stays 0.
- Read 0x4000_5000, slave 5 drives 0x1234_5678 after 3 wait states -> m_prdata=0x1234_5678 on the 4th access cycle, m_pslverr=0.
- Read 0x5000_0000 (unmapped) -> s_psel=0, then pready=1, pslverr=1, prdata=0 in the first access cycle, last_err_type=01, last_err_addr=0x5000_0000, err_count=1.
- Slave 3 never asserts pready, T=16 -> abort on access cycle 17 (s_psel=0, pslverr=1); a slave pready on cycle 18 is ignored; last_err_type=10.
- Slave 1 completes with pslverr=1 while err_clr is pulsed in the same cycle -> err_count=1, last_err_type=11; err_clr alone on the next cycle -> all status registers 0.
- preset_n asserted in the 2nd access cycle of a waited transfer -> outputs take reset values immediately; after release, a clean transfer to slave 0 succeeds.
